invz_bus_driver: RTL



---
 rtl/invz_bus_driver_pkg.sv | 23 ++
 rtl/invz_rr_pick.sv | 30 +++
 rtl/invz_bus_driver.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/invz_bus_driver_pkg.sv
// rtl/invz_bus_driver_pkg.sv - shared types and width helpers for the inverting bus driver
package invz_bus_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_TURN  = 2'd2
  } state_e;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int DEF_NCH       = 3;
  localparam int DEF_TURN      = 2;
  localparam int DEF_MAX_BURST = 4;

  localparam int DEF_PTR_W   = cnt_width(DEF_NCH - 1);
  localparam int DEF_BURST_W = cnt_width(DEF_MAX_BURST);
  localparam int DEF_TURN_W  = cnt_width(DEF_TURN);

endpackage

// File: rtl/invz_rr_pick.sv
// rtl/invz_rr_pick.sv - combinational round-robin winner search starting at a pointer
module invz_rr_pick
  import invz_bus_driver_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int PW  = DEF_PTR_W
) (
  input  logic [NCH-1:0] req_i,
  input  logic [PW-1:0]  ptr_i,
  output logic [PW-1:0]  win_o,
  output logic           valid_o
);

  int idx;

  // First requester at or above the pointer, wrapping modulo NCH.
  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int i = 0; i < NCH; i++) begin
      idx = (int'(ptr_i) + i) % NCH;
      if (!valid_o && req_i[idx[PW-1:0]]) begin
        valid_o = 1'b1;
        win_o   = idx[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/invz_bus_driver.sv
// rtl/invz_bus_driver.sv - round-robin shared-bus driver with inverted tri-state output
module invz_bus_driver
  import invz_bus_driver_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NCH       = DEF_NCH,
  parameter int TURN      = DEF_TURN,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic [NCH-1:0]       REQ,
  input  logic [NCH*WIDTH-1:0] I,
  output logic [NCH-1:0]       GNT,
  output wire  [WIDTH-1:0]     ZN,
  output logic                 OE,
  inout  wire                  VDD,
  inout  wire                  VSS
);

  localparam int PW = cnt_width(NCH - 1);
  localparam int BW = cnt_width(MAX_BURST);
  localparam int TW = cnt_width(TURN);

  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
  localparam logic [TW-1:0] TURN_LOAD = TW'(TURN);
  localparam logic [PW-1:0] LAST_CH   = PW'(NCH - 1);

  state_e           state_q, state_d;
  logic [NCH-1:0]   gnt_q, gnt_d;
  logic             oe_q, oe_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    win_q, win_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [TW-1:0]    turn_q, turn_d;

  logic [PW-1:0]    pick_win;
  logic             pick_valid;
  logic             arbitrate;
  logic [NCH-1:0]   owner_mask;
  logic             others_req;
  logic [PW-1:0]    ptr_after_owner;

  invz_rr_pick #(
    .NCH (NCH),
    .PW  (PW)
  ) u_pick (
    .req_i   (REQ),
    .ptr_i   (ptr_q),
    .win_o   (pick_win),
    .valid_o (pick_valid)
  );

  assign owner_mask      = NCH'(1) << win_q;
  assign others_req      = |(REQ & ~owner_mask);
  assign ptr_after_owner = (win_q == LAST_CH) ? '0 : win_q + PW'(1);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    oe_d      = oe_q;
    data_d    = data_q;
    ptr_d     = ptr_q;
    win_d     = win_q;
    burst_d   = burst_q;
    turn_d    = turn_q;
    arbitrate = 1'b0;

    case (state_q)
      ST_IDLE: arbitrate = 1'b1;

      ST_DRIVE: begin
        if (!REQ[win_q] || (burst_q == BURST_MAX && others_req)) begin
          state_d = ST_TURN;
          gnt_d   = '0;
          oe_d    = 1'b0;
          ptr_d   = ptr_after_owner;
          turn_d  = TURN_LOAD;
          burst_d = '0;
        end else begin
          data_d = I[int'(win_q)*WIDTH +: WIDTH];
          // Saturate so a lone requester keeps the bus indefinitely.
          if (burst_q != BURST_MAX) begin
            burst_d = burst_q + BW'(1);
          end
        end
      end

      ST_TURN: begin
        if (turn_q <= TW'(1)) begin
          turn_d    = '0;
          state_d   = ST_IDLE;
          arbitrate = 1'b1;
        end else begin
          turn_d = turn_q - TW'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // The final turnaround cycle hands over directly, so the gap is exactly TURN.
    if (arbitrate && pick_valid) begin
      state_d = ST_DRIVE;
      gnt_d   = NCH'(1) << pick_win;
      oe_d    = 1'b1;
      data_d  = I[int'(pick_win)*WIDTH +: WIDTH];
      win_d   = pick_win;
      burst_d = BW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      oe_q    <= 1'b0;
      data_q  <= '0;
      ptr_q   <= '0;
      win_q   <= '0;
      burst_q <= '0;
      turn_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      oe_q    <= oe_d;
      data_q  <= data_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      burst_q <= burst_d;
      turn_q  <= turn_d;
    end
  end

  assign GNT = gnt_q;
  assign OE  = oe_q;

  logic [WIDTH-1:0] data_n;
  assign data_n = ~data_q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_zn
    bufif1 u_zbuf (ZN[b], data_n[b], oe_q);
  end

  // Supply pins carry no logic.
  wire unused_supply;
  assign unused_supply = VDD ^ VSS;

endmodule
